// File: rtl/exp6_exibe_sequencia.sv
`default_nettype none
// ============================================================================
// Module      : exp6_exibe_sequencia
// Description : Plays the stored sequence back on the LEDs for the current
//               round. Addresses 0..rodada are read from the sequence ROM in
//               order. Each item is lit for T_on cycles, then followed by
//               T_APAGADO dark cycles. A one-cycle fim_exibicao pulse marks
//               the end of playback.
//
// Ports       : clock            - system clock, rising edge
//               reset            - synchronous, active-high reset
//               iniciar_exibicao - start request (only honoured when idle)
//               rodada[3:0]      - index of the last item to show
//               nivel_tempo      - 0 = slow, 1 = fast lit interval
//               dado_memoria[3:0]- ROM data for endereco (valid next cycle)
//               endereco[3:0]    - ROM read address
//               leds[3:0]        - displayed item, 0 when dark
//               exibindo         - high whenever not idle
//               fim_exibicao     - single-cycle end-of-playback pulse
//               db_estado[3:0]   - state code for the debug display
//
// Revision    : 1.0 - initial release
// ============================================================================
module exp6_exibe_sequencia #(
    parameter int T_ACESO        = 1000,
    parameter int T_ACESO_RAPIDO = 500,
    parameter int T_APAGADO      = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar_exibicao,
    input  logic [3:0] rodada,
    input  logic       nivel_tempo,
    input  logic [3:0] dado_memoria,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       fim_exibicao,
    output logic [3:0] db_estado
);

    // Timer must hold values up to the largest interval minus one.
    localparam int c_T_MAX_ON = (T_ACESO > T_ACESO_RAPIDO) ? T_ACESO : T_ACESO_RAPIDO;
    localparam int c_T_MAX    = (c_T_MAX_ON > T_APAGADO) ? c_T_MAX_ON : T_APAGADO;
    localparam int c_TW       = (c_T_MAX > 1) ? $clog2(c_T_MAX) : 1;

    localparam logic [c_TW-1:0] c_LENTO_LAST  = c_TW'(T_ACESO - 1);
    localparam logic [c_TW-1:0] c_RAPIDO_LAST = c_TW'(T_ACESO_RAPIDO - 1);
    localparam logic [c_TW-1:0] c_APAGA_LAST  = c_TW'(T_APAGADO - 1);
    localparam logic [c_TW-1:0] c_TIMER_ONE   = c_TW'(1);

    localparam logic [3:0] c_OCIOSO  = 4'd0;
    localparam logic [3:0] c_CARREGA = 4'd1;
    localparam logic [3:0] c_ACENDE  = 4'd2;
    localparam logic [3:0] c_APAGA   = 4'd3;
    localparam logic [3:0] c_PROXIMO = 4'd4;
    localparam logic [3:0] c_FIM     = 4'd5;

    logic [3:0]      r_estado,   w_estado_next;
    logic [3:0]      r_endereco, w_endereco_next;
    logic [3:0]      r_leds,     w_leds_next;
    logic [c_TW-1:0] r_timer,    w_timer_next;
    logic            r_fim,      w_fim_next;
    logic [3:0]      r_rodada,   w_rodada_next;
    logic            r_nivel,    w_nivel_next;
    logic [c_TW-1:0] w_on_last;

    // Speed is taken from the value captured at start, so mid-run changes
    // of nivel_tempo cannot disturb the current playback.
    assign w_on_last = r_nivel ? c_RAPIDO_LAST : c_LENTO_LAST;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= c_OCIOSO;
            r_endereco <= 4'd0;
            r_leds     <= 4'd0;
            r_timer    <= '0;
            r_fim      <= 1'b0;
            r_rodada   <= 4'd0;
            r_nivel    <= 1'b0;
        end else begin
            r_estado   <= w_estado_next;
            r_endereco <= w_endereco_next;
            r_leds     <= w_leds_next;
            r_timer    <= w_timer_next;
            r_fim      <= w_fim_next;
            r_rodada   <= w_rodada_next;
            r_nivel    <= w_nivel_next;
        end
    end

    always_comb begin
        w_estado_next   = r_estado;
        w_endereco_next = r_endereco;
        w_leds_next     = r_leds;
        w_timer_next    = r_timer;
        w_fim_next      = 1'b0;
        w_rodada_next   = r_rodada;
        w_nivel_next    = r_nivel;

        case (r_estado)
            c_OCIOSO: begin
                if (iniciar_exibicao) begin
                    w_rodada_next   = rodada;
                    w_nivel_next    = nivel_tempo;
                    w_endereco_next = 4'd0;
                    w_estado_next   = c_CARREGA;
                end
            end

            // One cycle for the ROM to present data for the new address.
            c_CARREGA: begin
                w_leds_next   = dado_memoria;
                w_timer_next  = '0;
                w_estado_next = c_ACENDE;
            end

            c_ACENDE: begin
                if (r_timer == w_on_last) begin
                    w_leds_next   = 4'd0;
                    w_timer_next  = '0;
                    w_estado_next = c_APAGA;
                end else begin
                    w_timer_next = r_timer + c_TIMER_ONE;
                end
            end

            c_APAGA: begin
                if (r_timer == c_APAGA_LAST) begin
                    w_timer_next = '0;
                    if (r_endereco == r_rodada) begin
                        // Pulse is registered so it lines up with the FIM state.
                        w_fim_next    = 1'b1;
                        w_estado_next = c_FIM;
                    end else begin
                        w_estado_next = c_PROXIMO;
                    end
                end else begin
                    w_timer_next = r_timer + c_TIMER_ONE;
                end
            end

            c_PROXIMO: begin
                w_endereco_next = r_endereco + 4'd1;
                w_estado_next   = c_CARREGA;
            end

            c_FIM: begin
                w_estado_next = c_OCIOSO;
            end

            default: begin
                w_estado_next = c_OCIOSO;
            end
        endcase
    end

    assign endereco     = r_endereco;
    assign leds         = r_leds;
    assign fim_exibicao = r_fim;
    assign exibindo     = (r_estado != c_OCIOSO);
    assign db_estado    = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_exp6_exibe_sequencia.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp6_exibe_sequencia
// Description : Scoreboard bench for exp6_exibe_sequencia. Stimulus pushes
//               expected events (exibindo rise/fall, each lit interval with
//               value/address/start/length, fim pulse) into a queue; a
//               monitor turns observed DUT outputs into events and compares.
//               Cycle numbers are relative to the start edge (edge 0).
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp6_exibe_sequencia;

    localparam int c_T_ACESO  = 4;
    localparam int c_T_RAPIDO = 2;
    localparam int c_T_APAGA  = 2;

    localparam int K_RISE = 0;
    localparam int K_LIT  = 1;
    localparam int K_FIM  = 2;
    localparam int K_FALL = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar_exibicao = 1'b0;
    logic [3:0] rodada = 4'd0;
    logic       nivel_tempo = 1'b0;
    logic [3:0] dado_memoria;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       exibindo;
    logic       fim_exibicao;
    logic [3:0] db_estado;

    logic [3:0] rom [16];

    exp6_exibe_sequencia #(
        .T_ACESO        (c_T_ACESO),
        .T_ACESO_RAPIDO (c_T_RAPIDO),
        .T_APAGADO      (c_T_APAGA)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .iniciar_exibicao (iniciar_exibicao),
        .rodada           (rodada),
        .nivel_tempo      (nivel_tempo),
        .dado_memoria     (dado_memoria),
        .endereco         (endereco),
        .leds             (leds),
        .exibindo         (exibindo),
        .fim_exibicao     (fim_exibicao),
        .db_estado        (db_estado)
    );

    // Asynchronous-read ROM: data valid in the cycle after endereco changes.
    assign dado_memoria = rom[endereco];

    always #5 clock = ~clock;

    int cyc = 0;
    int t0 = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int addr;
        int start;
        int len;
    } ev_t;

    ev_t q[$];

    task automatic push_ev(input int kind, input int val, input int addr,
                           input int start, input int len);
        ev_t e;
        e.kind = kind; e.val = val; e.addr = addr; e.start = start; e.len = len;
        q.push_back(e);
    endtask

    // Expected events of an undisturbed run: item i lights at cycle
    // 2 + i*(T_on+T_APAGADO+2); fim at 1 + (r+1)*(1+T_on+T_APAGADO) + r.
    task automatic push_run(input int r, input int lvl);
        int ton;
        int fim_c;
        ton   = lvl ? c_T_RAPIDO : c_T_ACESO;
        fim_c = 1 + (r + 1) * (1 + ton + c_T_APAGA) + r;
        push_ev(K_RISE, 0, 0, 1, 0);
        for (int i = 0; i <= r; i++)
            push_ev(K_LIT, int'(rom[i]), i, 2 + i * (ton + c_T_APAGA + 2), ton);
        push_ev(K_FIM, 0, r, fim_c, 0);
        push_ev(K_FALL, 0, 0, fim_c + 1, 0);
    endtask

    task automatic check_ev(input ev_t got);
        ev_t ex;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d addr=%0d cycle=%0d len=%0d, required none",
                     got.kind, got.val, got.addr, got.start, got.len);
        end else begin
            ex = q.pop_front();
            if (got.kind != ex.kind || got.val != ex.val || got.addr != ex.addr ||
                got.start != ex.start || got.len != ex.len) begin
                n_err++;
                $display("FAIL event: got kind=%0d val=%0d addr=%0d cycle=%0d len=%0d, required kind=%0d val=%0d addr=%0d cycle=%0d len=%0d",
                         got.kind, got.val, got.addr, got.start, got.len,
                         ex.kind, ex.val, ex.addr, ex.start, ex.len);
            end
        end
    endtask

    // Monitor
    logic [3:0] prev_leds = 4'd0;
    logic       prev_exib = 1'b0;
    int         lit_start = 0;
    int         lit_addr  = 0;
    int         lit_val   = 0;
    int         mon_rel;
    ev_t        mon_ev;

    always @(negedge clock) begin
        mon_rel = cyc - t0;
        if (exibindo && !prev_exib) begin
            mon_ev = '{K_RISE, 0, 0, mon_rel, 0};
            check_ev(mon_ev);
        end
        if (leds != 4'd0 && prev_leds == 4'd0) begin
            lit_start <= mon_rel;
            lit_val   <= int'(leds);
            lit_addr  <= int'(endereco);
        end
        if (leds == 4'd0 && prev_leds != 4'd0) begin
            mon_ev = '{K_LIT, lit_val, lit_addr, lit_start, mon_rel - lit_start};
            check_ev(mon_ev);
        end
        if (fim_exibicao) begin
            mon_ev = '{K_FIM, 0, int'(endereco), mon_rel, 0};
            check_ev(mon_ev);
        end
        if (!exibindo && prev_exib) begin
            mon_ev = '{K_FALL, 0, 0, mon_rel, 0};
            check_ev(mon_ev);
        end
        prev_leds <= leds;
        prev_exib <= exibindo;
    end

    task automatic check(input string name, input int got, input int exp_v);
        n_vec++;
        if (got != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp_v);
        end
    endtask

    // Start edge is the posedge following this negedge; returns at cycle 1.
    task automatic start(input int r, input int lvl);
        @(negedge clock);
        rodada           = 4'(r);
        nivel_tempo      = lvl[0];
        iniciar_exibicao = 1'b1;
        t0               = cyc;
        @(negedge clock);
        iniciar_exibicao = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending events, required 0", q.size());
            q.delete();
        end
        repeat (4) @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));

        repeat (3) @(negedge clock);
        check("rst_estado", int'(db_estado), 0);
        check("rst_leds", int'(leds), 0);
        check("rst_endereco", int'(endereco), 0);
        check("rst_exibindo", int'(exibindo), 0);
        check("rst_fim", int'(fim_exibicao), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single item, slow.
        push_run(0, 0);
        start(0, 0);
        check("carrega_state", int'(db_estado), 1);
        drain(50);

        // Three items, slow.
        push_run(2, 0);
        start(2, 0);
        drain(100);

        // Fast level; toggling nivel_tempo mid-run must not matter.
        push_run(0, 1);
        start(0, 1);
        nivel_tempo = 1'b0;
        drain(50);

        // Busy start plus input changes during ACENDE.
        push_run(2, 0);
        start(2, 0);
        repeat (2) @(negedge clock);
        check("acende_state", int'(db_estado), 2);
        iniciar_exibicao = 1'b1;
        rodada           = 4'd5;
        nivel_tempo      = 1'b1;
        @(negedge clock);
        iniciar_exibicao = 1'b0;
        drain(100);

        // Reset during the second item (lit cycles 10..13); sampled at edge 11.
        push_ev(K_RISE, 0, 0, 1, 0);
        push_ev(K_LIT, int'(rom[0]), 0, 2, 4);
        push_ev(K_LIT, int'(rom[1]), 1, 10, 2);
        push_ev(K_FALL, 0, 0, 12, 0);
        start(3, 0);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_estado", int'(db_estado), 0);
        check("midrst_leds", int'(leds), 0);
        check("midrst_endereco", int'(endereco), 0);
        check("midrst_fim", int'(fim_exibicao), 0);
        reset = 1'b0;
        drain(50);

        // Replay after reset starts from address 0.
        push_run(0, 0);
        start(0, 0);
        drain(50);

        // Full length.
        push_run(15, 0);
        start(15, 0);
        drain(300);
        check("full_endereco_hold", int'(endereco), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
